// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid FSM state encoding, per-stage
// control payload structs that callers pack into i_data, and a small helper
// mapping FSM state to the number of held entries.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  // Execute-stage control bundle
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       is_branch;
    logic       is_jump;
  } ex_ctrl_t;

  // Memory-stage control bundle
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
  } mem_ctrl_t;

  // Writeback-stage control bundle
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } wb_ctrl_t;

  // Entries held for a given state; any unknown encoding reads as empty
  function automatic logic [1:0] state_count(input pipe_state_t s);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (s)
      PS_ONE:  cnt = 2'd1;
      PS_TWO:  cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic buffer with registered o_ready.
// Entries: main (drives o_data) and skid (catches the word accepted in the
// cycle downstream stalls, since o_ready was already committed high).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             kill all held entries
//   i_valid/o_ready     upstream handshake, i_data payload
//   o_valid/i_ready     downstream handshake, o_data payload
//   o_count             entries held (0..2)
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CLEAR_DATA = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign o_ready  = ready_q;
  assign o_data   = main_q;
  assign in_fire  = i_valid & ready_q;
  assign out_fire = o_valid & i_ready;

  // State register; o_ready is precomputed from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PS_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != PS_TWO);
    end
  end

  // Next-state logic; illegal encodings fall back to EMPTY
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: if (in_fire) state_d = PS_ONE;
        PS_ONE: begin
          if (in_fire && !out_fire)      state_d = PS_TWO;
          else if (out_fire && !in_fire) state_d = PS_EMPTY;
        end
        PS_TWO:   if (out_fire) state_d = PS_ONE;
        default:  state_d = PS_EMPTY;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    o_valid = 1'b0;
    o_count = state_count(state_q);
    case (state_q)
      PS_ONE:  o_valid = 1'b1;
      PS_TWO:  o_valid = 1'b1;
      default: o_valid = 1'b0;
    endcase
  end

  // Entry datapath; main only changes when it is not presenting a stalled word
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      if (CLEAR_DATA != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: if (in_fire) main_q <= i_data;
        PS_ONE: begin
          if (in_fire && out_fire) main_q <= i_data;
          else if (in_fire)        skid_q <= i_data;
        end
        PS_TWO:   if (out_fire) main_q <= skid_q;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline-stage register with valid/ready handshake,
// flush, and optional two-entry skid that registers o_ready.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             kill all held entries (redirect)
//   i_valid/o_ready     upstream handshake, i_data payload
//   o_valid/i_ready     downstream handshake, o_data payload
//   o_count             entries held
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SKID       = 0,
  parameter int unsigned CLEAR_DATA = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  generate
    if (SKID == 0) begin : g_single
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic             in_fire;

      // Ready passes through combinationally so a full stage can refill
      // in the same cycle it drains
      assign o_ready = ~valid_q | i_ready;
      assign in_fire = i_valid & o_ready;
      assign o_valid = valid_q;
      assign o_data  = data_q;
      assign o_count = {1'b0, valid_q};

      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
          valid_q <= 1'b0;
          if (CLEAR_DATA != 0) data_q <= '0;
        end else if (in_fire) begin
          valid_q <= 1'b1;
          data_q  <= i_data;
        end else if (i_ready) begin
          // Drained without refill: data is left as-is
          valid_q <= 1'b0;
        end
      end
    end else begin : g_skid
      pipe_skid_buf #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
      );
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a single-entry stage (32b) and a skid stage
// (75b) share one stimulus stream. Each has a queue-based model; a monitor
// compares every cycle and pops on downstream transfers.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst, flush, vld, rdy;
  logic [74:0] dat;

  logic        o_ready0, o_valid0;
  logic [31:0] o_data0;
  logic [1:0]  o_count0;
  logic        o_ready1, o_valid1;
  logic [74:0] o_data1;
  logic [1:0]  o_count1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [74:0] q0[$];
  logic [74:0] q1[$];
  logic [74:0] last0 = '0;
  logic [74:0] last1 = '0;
  int          out_cnt0 = 0;
  int          out_cnt1 = 0;
  logic        acc1 = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(32), .SKID(0), .CLEAR_DATA(1)) d0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vld), .o_ready(o_ready0),
    .i_data(dat[31:0]), .o_valid(o_valid0), .i_ready(rdy), .o_data(o_data0),
    .o_count(o_count0)
  );

  pipe_stage_elastic #(.WIDTH(75), .SKID(1), .CLEAR_DATA(1)) d1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vld), .o_ready(o_ready1),
    .i_data(dat), .o_valid(o_valid1), .i_ready(rdy), .o_data(o_data1),
    .o_count(o_count1)
  );

  task automatic chk(input string nm, input logic [74:0] act, input logic [74:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Monitor/model for the single-entry stage: one slot, ready when empty or draining
  always @(negedge clk) begin
    logic ev, er;
    #1;
    ev = (q0.size() != 0);
    er = (q0.size() == 0) || rdy;
    chk("d0_valid", 75'(o_valid0), 75'(ev));
    chk("d0_data",  75'(o_data0), ev ? q0[0] : last0);
    chk("d0_count", 75'(o_count0), 75'(q0.size()));
    chk("d0_ready", 75'(o_ready0), 75'(er));
    if (rst || flush) begin
      q0.delete();
      last0 = '0;
    end else begin
      if (ev && rdy) begin
        last0 = q0.pop_front();
        out_cnt0++;
      end
      if (vld && er) q0.push_back(75'(dat[31:0]));
    end
  end

  // Monitor/model for the skid stage: up to two words, ready decided by prior occupancy
  always @(negedge clk) begin
    logic ev, er;
    #1;
    ev = (q1.size() != 0);
    er = (q1.size() < 2);
    chk("d1_valid", 75'(o_valid1), 75'(ev));
    chk("d1_data",  o_data1, ev ? q1[0] : last1);
    chk("d1_count", 75'(o_count1), 75'(q1.size()));
    chk("d1_ready", 75'(o_ready1), 75'(er));
    acc1 = vld && er;
    if (rst || flush) begin
      q1.delete();
      last1 = '0;
    end else begin
      if (ev && rdy) begin
        last1 = q1.pop_front();
        out_cnt1++;
      end
      if (vld && er) q1.push_back(dat);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld = 1'b0;
      rdy = 1'b1;
      flush = 1'b0;
      rst = 1'b0;
    end
  endtask

  initial begin
    int base0, base1;
    bit got;

    // Reset held with garbage on the input
    rst = 1'b1; flush = 1'b0; vld = 1'b1; rdy = 1'b1; dat = 75'h0DEADBEEF;
    repeat (2) @(negedge clk);
    rst = 1'b0; vld = 1'b0;
    #2;
    chk("rst_ready1", 75'(o_ready1), 75'(1));
    chk("rst_data1", o_data1, 75'(0));
    idle(2);

    // Back-to-back stream 1..8, no stall
    base0 = out_cnt0; base1 = out_cnt1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vld = 1'b1; rdy = 1'b1; dat = 75'(i);
    end
    @(negedge clk);
    vld = 1'b0;
    #2;
    chk("stream_gapless0", 75'(out_cnt0 - base0), 75'(8));
    chk("stream_gapless1", 75'(out_cnt1 - base1), 75'(8));
    idle(3);

    // Stall with A,B,C: skid fills, C waits upstream
    @(negedge clk); vld = 1'b1; rdy = 1'b0; dat = 75'hA;
    @(negedge clk); dat = 75'hB;
    @(negedge clk); dat = 75'hC;
    @(negedge clk);
    #2;
    chk("stall_count2", 75'(o_count1), 75'(2));
    chk("stall_ready0", 75'(o_ready1), 75'(0));
    chk("stall_dataA", o_data1, 75'hA);
    @(negedge clk);
    rdy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #2;
      if (acc1) got = 1'b1;
    end
    chk("stall_C_accepted", 75'(got), 75'(1));
    idle(4);

    // Flush while full, with a live input word that must vanish
    @(negedge clk); vld = 1'b1; rdy = 1'b0; dat = 75'h11;
    @(negedge clk); dat = 75'h22;
    @(negedge clk); flush = 1'b1; dat = 75'h7FF_BAD0_BAD0_BAD0_BAD;
    @(negedge clk); flush = 1'b0; vld = 1'b0;
    #2;
    chk("flush_valid", 75'(o_valid1), 75'(0));
    chk("flush_count", 75'(o_count1), 75'(0));
    chk("flush_data", o_data1, 75'(0));
    idle(4);

    // Reset while stalled and holding two entries
    @(negedge clk); vld = 1'b1; rdy = 1'b0; dat = 75'h33;
    @(negedge clk); dat = 75'h44;
    @(negedge clk); rst = 1'b1; dat = 75'h0DEADBEEF;
    @(negedge clk); rst = 1'b0; vld = 1'b0;
    #2;
    chk("rst_mid_valid", 75'(o_valid1), 75'(0));
    chk("rst_mid_ready", 75'(o_ready1), 75'(1));
    chk("rst_mid_data", o_data1, 75'(0));
    idle(4);

    // Random traffic with occasional flush/reset
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      vld   = 1'($urandom_range(0, 1));
      rdy   = 1'($urandom_range(0, 1));
      dat   = 75'({$urandom(), $urandom(), $urandom()});
      flush = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 511) == 0);
    end
    idle(6);
    #2;
    chk("drain_q0", 75'(q0.size()), 75'(0));
    chk("drain_q1", 75'(q1.size()), 75'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
